ether_import: RTL and testbench

- RMII receive-side counterpart of the framebuffer Ethernet exporter.
- Samples eth_crsdv/eth_rxd, strips preamble/SFD and classifies each packet as frame-start or row packet.
- Writes received 4-bit grayscale pixels into a framebuffer BRAM write port.
- Sits between the RMII PHY pins and the display-side framebuffer; one pixel write per two payload dibits.

---
 rtl/ether_import.sv | 241 ++++++++++++++++++++++++
 tb/tb_ether_import.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ether_import.sv
// ether_import: RMII receiver that turns frame-start and row packets into framebuffer pixel writes.
// Define ETHER_IMPORT_SEQ_CHECK_EN to accept rows only in order, starting after a frame-start packet.
module ether_import #(
  parameter int DISPLAY_WIDTH  = 320,
  parameter int DISPLAY_HEIGHT = 240,
  parameter int ADDR_BITS      = 17
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 eth_crsdv,
  input  logic [1:0]           eth_rxd,
  output logic [ADDR_BITS-1:0] write_addr_out,
  output logic [3:0]           write_data_out,
  output logic                 write_en_out,
  output logic                 frame_start_out,
  output logic                 frame_done_out,
  output logic                 error_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_HEADER,
    S_FSTART,
    S_PIXELS,
    S_DRAIN
  } state_t;

  localparam logic [15:0] WIDTH16     = 16'(DISPLAY_WIDTH);
  localparam logic [15:0] HEIGHT16    = 16'(DISPLAY_HEIGHT);
  localparam logic [15:0] FSTART_ROW  = 16'hFFFF;
  localparam logic [6:0]  FSTART_TAIL = 7'd92;
  localparam logic [4:0]  PRE_MIN     = 5'd4;
  localparam logic [4:0]  PRE_MAX     = 5'd31;

  logic                 crsdv_q;
  logic [1:0]           rxd_q;

  state_t               state_q, state_d;
  logic [4:0]           pre_cnt_q, pre_cnt_d;
  logic [6:0]           cnt_q, cnt_d;
  logic [15:0]          row_q, row_d;
  logic [15:0]          col_q, col_d;
  logic                 half_q, half_d;
  logic [1:0]           pix_hi_q, pix_hi_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [3:0]           data_q, data_d;
  logic                 we_q, we_d;
  logic                 fs_q, fs_d;
  logic                 fd_q, fd_d;
  logic                 err_q, err_d;

  logic [15:0]          row_full;
  logic                 row_in_seq;

`ifdef ETHER_IMPORT_SEQ_CHECK_EN
  logic [15:0]          exp_row_q, exp_row_d;
  assign row_in_seq = (row_full == exp_row_q);
`else
  assign row_in_seq = 1'b1;
`endif

  // Row number as it stands once the eighth header dibit (bits 15:14) arrives.
  assign row_full = {rxd_q, row_q[13:0]};

  always_ff @(posedge clk_in) begin
    crsdv_q <= eth_crsdv;
    rxd_q   <= eth_rxd;
  end

  always_comb begin
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    cnt_d     = cnt_q;
    row_d     = row_q;
    col_d     = col_q;
    half_d    = half_q;
    pix_hi_d  = pix_hi_q;
    addr_d    = addr_q;
    data_d    = data_q;
    we_d      = 1'b0;
    fs_d      = 1'b0;
    fd_d      = 1'b0;
    err_d     = 1'b0;
`ifdef ETHER_IMPORT_SEQ_CHECK_EN
    exp_row_d = exp_row_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (crsdv_q) begin
          if (rxd_q == 2'b01) begin
            state_d   = S_PREAMBLE;
            pre_cnt_d = 5'd1;
          end else if (rxd_q != 2'b00) begin
            err_d   = 1'b1;
            state_d = S_DRAIN;
          end
        end
      end

      S_PREAMBLE: begin
        if (!crsdv_q) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (rxd_q == 2'b01) begin
          if (pre_cnt_q != PRE_MAX) pre_cnt_d = pre_cnt_q + 5'd1;
        end else if (rxd_q == 2'b11 && pre_cnt_q >= PRE_MIN) begin
          state_d = S_HEADER;
          cnt_d   = 7'd0;
          row_d   = 16'd0;
        end else begin
          err_d   = 1'b1;
          state_d = S_DRAIN;
        end
      end

      S_HEADER: begin
        if (!crsdv_q) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          row_d[{cnt_q[2:0], 1'b0} +: 2] = rxd_q;
          cnt_d = cnt_q + 7'd1;
          if (cnt_q == 7'd7) begin
            cnt_d = 7'd0;
            if (row_full == FSTART_ROW) begin
              state_d = S_FSTART;
            end else if (row_full < HEIGHT16 && row_in_seq) begin
              state_d = S_PIXELS;
              col_d   = 16'd0;
              half_d  = 1'b0;
            end else begin
              err_d   = 1'b1;
              state_d = S_DRAIN;
            end
          end
        end
      end

      // Header already supplied 8 of the 100 all-ones dibits; cnt_q tracks the rest.
      S_FSTART: begin
        if (!crsdv_q) begin
          state_d = S_IDLE;
          if (cnt_q == FSTART_TAIL) begin
            fs_d = 1'b1;
`ifdef ETHER_IMPORT_SEQ_CHECK_EN
            exp_row_d = 16'd0;
`endif
          end else begin
            err_d = 1'b1;
          end
        end else if (rxd_q != 2'b11 || cnt_q == FSTART_TAIL) begin
          err_d   = 1'b1;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end

      S_PIXELS: begin
        if (!crsdv_q) begin
          state_d = S_IDLE;
          if (col_q == WIDTH16) begin
            if (row_q == HEIGHT16 - 16'd1) fd_d = 1'b1;
`ifdef ETHER_IMPORT_SEQ_CHECK_EN
            exp_row_d = exp_row_q + 16'd1;
`endif
          end else begin
            err_d = 1'b1;
          end
        end else if (col_q == WIDTH16) begin
          err_d   = 1'b1;
          state_d = S_DRAIN;
        end else if (!half_q) begin
          pix_hi_d = rxd_q;
          half_d   = 1'b1;
        end else begin
          we_d   = 1'b1;
          addr_d = ADDR_BITS'(row_q) * ADDR_BITS'(DISPLAY_WIDTH) + ADDR_BITS'(col_q);
          data_d = {pix_hi_q, rxd_q};
          col_d  = col_q + 16'd1;
          half_d = 1'b0;
        end
      end

      S_DRAIN: begin
        if (!crsdv_q) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // A reset while the PHY is mid-packet must not resync on the packet's tail.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= eth_crsdv ? S_DRAIN : S_IDLE;
      pre_cnt_q <= 5'd0;
      cnt_q     <= 7'd0;
      row_q     <= 16'd0;
      col_q     <= 16'd0;
      half_q    <= 1'b0;
      pix_hi_q  <= 2'd0;
      addr_q    <= '0;
      data_q    <= 4'd0;
      we_q      <= 1'b0;
      fs_q      <= 1'b0;
      fd_q      <= 1'b0;
      err_q     <= 1'b0;
`ifdef ETHER_IMPORT_SEQ_CHECK_EN
      exp_row_q <= HEIGHT16;
`endif
    end else begin
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
      cnt_q     <= cnt_d;
      row_q     <= row_d;
      col_q     <= col_d;
      half_q    <= half_d;
      pix_hi_q  <= pix_hi_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      we_q      <= we_d;
      fs_q      <= fs_d;
      fd_q      <= fd_d;
      err_q     <= err_d;
`ifdef ETHER_IMPORT_SEQ_CHECK_EN
      exp_row_q <= exp_row_d;
`endif
    end
  end

  assign write_addr_out  = addr_q;
  assign write_data_out  = data_q;
  assign write_en_out    = we_q;
  assign frame_start_out = fs_q;
  assign frame_done_out  = fd_q;
  assign error_out       = err_q;

endmodule

// File: tb/tb_ether_import.sv
// tb_ether_import: drives directed and random RMII packets into ether_import and checks
// every framebuffer write and per-packet pulse against a packet-level reference model.
module tb_ether_import;

  localparam int W  = 320;
  localparam int H  = 240;
  localparam int AB = 17;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          eth_crsdv;
  logic [1:0]    eth_rxd;
  logic [AB-1:0] write_addr_out;
  logic [3:0]    write_data_out;
  logic          write_en_out;
  logic          frame_start_out;
  logic          frame_done_out;
  logic          error_out;

  ether_import #(
    .DISPLAY_WIDTH (W),
    .DISPLAY_HEIGHT(H),
    .ADDR_BITS     (AB)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .eth_crsdv      (eth_crsdv),
    .eth_rxd        (eth_rxd),
    .write_addr_out (write_addr_out),
    .write_data_out (write_data_out),
    .write_en_out   (write_en_out),
    .frame_start_out(frame_start_out),
    .frame_done_out (frame_done_out),
    .error_out      (error_out)
  );

  always #10 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  wr_t exp_q[$];
  int  compared   = 0;
  int  mismatched = 0;
  int  n_writes   = 0;
  int  n_fs       = 0;
  int  n_fd       = 0;
  int  n_err      = 0;
  bit  mon_en     = 1'b0;
  int  m_exp_row  = H;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic dv, input logic [1:0] d);
    @(posedge clk_in);
    #1;
    eth_crsdv = dv;
    eth_rxd   = d;
  endtask

  // Every cycle: a write must appear exactly when the model scheduled one.
  always @(negedge clk_in) begin : monitor
    wr_t  e;
    logic exp_we;
    if (mon_en) begin
      while (exp_q.size() != 0 && exp_q[0].cyc < cyc) void'(exp_q.pop_front());
      exp_we = (exp_q.size() != 0 && exp_q[0].cyc == cyc);
      checkOutput("write_en timing", 32'(write_en_out), 32'(exp_we));
      if (exp_we) begin
        e = exp_q.pop_front();
        if (write_en_out) begin
          checkOutput("write_addr", 32'(write_addr_out), e.addr);
          checkOutput("write_data", 32'(write_data_out), e.data);
        end
      end
      if (write_en_out)    n_writes++;
      if (frame_start_out) n_fs++;
      if (frame_done_out)  n_fd++;
      if (error_out)       n_err++;
    end
  end

  task automatic finishPacket(input string name, input int w0, input int fs0, input int fd0,
                              input int e0, input int exp_w, input int exp_fs, input int exp_fd,
                              input int exp_err);
    repeat (6) applyStimulus(1'b0, 2'b00);
    checkOutput({name, " writes"}, n_writes - w0, exp_w);
    checkOutput({name, " frame_start"}, n_fs - fs0, exp_fs);
    checkOutput({name, " frame_done"}, n_fd - fd0, exp_fd);
    checkOutput({name, " error"}, n_err - e0, exp_err);
  endtask

  task automatic sendPreamble(input int npre);
    repeat (npre) applyStimulus(1'b1, 2'b01);
    applyStimulus(1'b1, 2'b11);
  endtask

  task automatic sendFrameStart(input string name, input int npre, input int n);
    int w0 = n_writes;
    int fs0 = n_fs;
    int fd0 = n_fd;
    int e0 = n_err;
    int ok;
    ok = (npre >= 4 && n == 100) ? 1 : 0;
    sendPreamble(npre);
    repeat (n) applyStimulus(1'b1, 2'b11);
    if (ok != 0) m_exp_row = 0;
    finishPacket(name, w0, fs0, fd0, e0, 0, ok, 0, 1 - ok);
  endtask

  task automatic sendRowPacket(input string name, input int npre, input int row, input int npix,
                               input int extra, input int rst_at, input bit rand_pix);
    int          w0 = n_writes;
    int          fs0 = n_fs;
    int          fd0 = n_fd;
    int          e0 = n_err;
    int          exp_w = 0;
    int          pix;
    bit          accepted;
    bit          complete;
    logic [15:0] row16;
    row16    = 16'(row);
    accepted = (npre >= 4 && row < H);
`ifdef ETHER_IMPORT_SEQ_CHECK_EN
    accepted = accepted && (row == m_exp_row);
`endif
    complete = accepted && npix == W && extra == 0 && rst_at < 0;
    sendPreamble(npre);
    for (int k = 0; k < 8; k++) applyStimulus(1'b1, row16[2*k +: 2]);
    for (int c = 0; c < npix; c++) begin
      pix = rand_pix ? int'($urandom_range(15)) : c % 16;
      applyStimulus(1'b1, 2'(pix >> 2));
      if (rst_in && c == rst_at + 1) rst_in = 1'b0;
      if (c == rst_at) begin
        // Reset lands on the next edge: any write due from then on is cancelled.
        rst_in = 1'b1;
        while (exp_q.size() != 0 && exp_q[$].cyc >= cyc + 1) begin
          void'(exp_q.pop_back());
          exp_w--;
        end
        accepted  = 1'b0;
        m_exp_row = H;
      end
      applyStimulus(1'b1, 2'(pix));
      if (c == rst_at) begin
        checkOutput("reset write_en", 32'(write_en_out), 0);
        checkOutput("reset write_addr", 32'(write_addr_out), 0);
        checkOutput("reset error", 32'(error_out), 0);
        checkOutput("reset frame_done", 32'(frame_done_out), 0);
      end
      if (accepted) begin
        exp_q.push_back('{addr: row * W + c, data: pix, cyc: cyc + 2});
        exp_w++;
      end
    end
    repeat (extra) applyStimulus(1'b1, 2'($urandom_range(3)));
    if (complete) m_exp_row++;
    finishPacket(name, w0, fs0, fd0, e0, exp_w, 0,
                 (complete && row == H - 1) ? 1 : 0,
                 (rst_at < 0 && !complete) ? 1 : 0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int kind;
    int npre;
    int row;
    rst_in    = 1'b1;
    eth_crsdv = 1'b0;
    eth_rxd   = 2'b00;
    repeat (3) applyStimulus(1'b0, 2'b00);
    checkOutput("rst write_en", 32'(write_en_out), 0);
    checkOutput("rst write_addr", 32'(write_addr_out), 0);
    checkOutput("rst write_data", 32'(write_data_out), 0);
    checkOutput("rst frame_start", 32'(frame_start_out), 0);
    checkOutput("rst frame_done", 32'(frame_done_out), 0);
    checkOutput("rst error", 32'(error_out), 0);
    rst_in = 1'b0;
    mon_en = 1'b1;
    repeat (2) applyStimulus(1'b0, 2'b00);

    sendRowPacket("row5", 15, 5, W, 0, -1, 1'b0);
    sendFrameStart("fstart", 15, 100);
    sendRowPacket("row239", 8, 239, W, 0, -1, 1'b1);
    sendRowPacket("row240", 8, 240, W, 0, -1, 1'b1);
    sendRowPacket("trunc10", 8, 7, 10, 0, -1, 1'b1);
    sendRowPacket("extra2", 8, 8, W, 2, -1, 1'b1);
    sendRowPacket("short_pre", 2, 9, W, 0, -1, 1'b1);
    sendRowPacket("reset_mid", 8, 10, W, 0, 40, 1'b1);
    sendRowPacket("after_reset", 6, 11, W, 0, -1, 1'b1);
    sendFrameStart("fstart99", 8, 99);
    sendFrameStart("fstart101", 8, 101);
    sendFrameStart("fstart_seq", 8, 100);
    sendRowPacket("seq_row0", 8, 0, W, 0, -1, 1'b1);
    sendRowPacket("seq_row2", 8, 2, W, 0, -1, 1'b1);

    for (int i = 0; i < 8; i++) begin
      kind = int'($urandom_range(3));
      npre = int'($urandom_range(12, 2));
      row  = int'($urandom_range(H + 15));
      case (kind)
        0:       sendRowPacket("rand_full", npre, row, W, 0, -1, 1'b1);
        1:       sendRowPacket("rand_trunc", npre, row, int'($urandom_range(W - 1)), 0, -1, 1'b1);
        2:       sendRowPacket("rand_extra", npre, row, W, int'($urandom_range(3, 1)), -1, 1'b1);
        default: sendFrameStart("rand_fstart", npre, int'($urandom_range(102, 98)));
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
